// File: rtl/pc_sequencer.sv
// Program-counter sequencer: turns redirect, stall and halt requests into PC commands
// and keeps a small return-address stack for call/return redirects.
module pc_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] pc_in,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_type,
    input  logic [31:0] redir_target,
    input  logic        halt,
    input  logic        resume,
    output logic [1:0]  ctrl,
    output logic [31:0] jump,
    output logic        redir_ready,
    output logic        flush,
    output logic        stk_ovf,
    output logic        stk_unf
);

    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW = AW + 1;

    localparam logic [1:0] CMD_INC  = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_HOLD = 2'b10;

    localparam logic [1:0] RT_JUMP = 2'b00;
    localparam logic [1:0] RT_CALL = 2'b01;
    localparam logic [1:0] RT_RET  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FLUSH  = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [31:0]      stk_q [STACK_DEPTH];
    logic [AW-1:0]    top_idx;
    logic             stk_full, stk_empty;
    logic [1:0]       fetch_cmd;

    assign top_idx   = AW'(sp_q - SPW'(1));
    assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
    assign stk_empty = (sp_q == '0);
    assign fetch_cmd = (!stall && imem_ready) ? CMD_INC : CMD_HOLD;

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        push        = 1'b0;
        ctrl        = CMD_HOLD;
        jump        = 32'd0;
        redir_ready = 1'b0;
        flush       = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_RUN;

            S_RUN: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (redir_valid) begin
                    redir_ready = 1'b1;
                    case (redir_type)
                        RT_JUMP, RT_CALL: begin
                            ctrl    = CMD_LOAD;
                            jump    = redir_target;
                            state_d = S_FLUSH;
                            if (redir_type == RT_CALL) begin
                                if (stk_full) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    push = 1'b1;
                                    sp_d = sp_q + SPW'(1);
                                end
                            end
                        end
                        RT_RET: begin
                            if (stk_empty) begin
                                unf_d = 1'b1;
                            end else begin
                                ctrl    = CMD_LOAD;
                                jump    = stk_q[top_idx];
                                sp_d    = sp_q - SPW'(1);
                                state_d = S_FLUSH;
                            end
                        end
                        default: ctrl = fetch_cmd;
                    endcase
                end else begin
                    ctrl = fetch_cmd;
                end
            end

            S_FLUSH: begin
                flush   = 1'b1;
                state_d = halt ? S_HALTED : S_RUN;
            end

            default: begin
                if (resume && !halt) state_d = S_RUN;
            end
        endcase

        // Reset forces the quiet command set regardless of state.
        if (!RST) begin
            ctrl        = CMD_HOLD;
            jump        = 32'd0;
            redir_ready = 1'b0;
            flush       = 1'b0;
            push        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stk_q[sp_q[AW-1:0]] <= pc_in + 32'd1;
    end

    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, return-address stack entries (power of 2, 2..16).
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-low.
REQ-004 pc_in  in  32  current program counter value (IADDR from program counter).
REQ-005 imem_ready  in  1  instruction memory accepted current fetch address this cycle.
REQ-006 stall  in  1  pipeline stall request, holds PC.
REQ-007 redir_valid  in  1  redirect request.
REQ-008 redir_type  in  2  00 jump, 01 call, 10 return, 11 reserved.
REQ-009 redir_target  in  32  jump/call target address.
REQ-010 halt  in  1  enter HALTED.
REQ-011 resume  in  1  leave HALTED.
REQ-012 ctrl  out  2  PC command: 00 increment, 01 load jump, 10 hold (11 never driven).
REQ-013 jump  out  32  PC load value, valid when ctrl=01, 0 otherwise.
REQ-014 redir_ready  out  1  redirect accepted this cycle when redir_valid also high.
REQ-015 flush  out  1  discard the fetched instruction in flight.
REQ-016 stk_ovf  out  1  sticky call-with-full-stack error.
REQ-017 stk_unf  out  1  sticky return-with-empty-stack error.

Function
REQ-018 FSM states IDLE, RUN, FLUSH, HALTED; ctrl, jump, redir_ready, flush decoded combinationally from state and inputs.
REQ-019 IDLE: ctrl=10; unconditional transition to RUN next cycle.
REQ-020 RUN priority: halt > redirect > stall > imem_ready.
REQ-021 RUN, halt=1: ctrl=10, redir_ready=0, next HALTED; a simultaneous redirect is dropped.
REQ-022 RUN, redir_valid=1, type 00: redir_ready=1, ctrl=01, jump=redir_target, next FLUSH; stall and imem_ready ignored.
REQ-023 RUN, type 01 (call): as jump, plus push pc_in+1 (mod 2^32) on the stack at the same edge.
REQ-024 Call with stack full (STACK_DEPTH entries): jump still taken, push discarded, stk_ovf set.
REQ-025 RUN, type 10 (return) with stack non-empty: ctrl=01, jump=top entry, pop at the same edge, next FLUSH.
REQ-026 Return with stack empty: redir_ready=1, ctrl=10, stk_unf set, remain RUN.
REQ-027 Type 11: redir_ready=1, request consumed as a no-op; normal stall/imem_ready rules apply.
REQ-028 RUN, no redirect: ctrl=00 if stall=0 and imem_ready=1, else ctrl=10.
REQ-029 FLUSH: flush=1, ctrl=10, redir_ready=0, one cycle, then RUN (HALTED if halt=1).
REQ-030 HALTED: ctrl=10, redir_ready=0; resume=1 moves to RUN next cycle; halt and resume both high stays HALTED.
REQ-031 Stack pointer counts 0..STACK_DEPTH with no wrap; entries survive HALTED.
REQ-032 stk_ovf and stk_unf, once set, stay set until reset.
REQ-033 redir_ready=0 in every state except RUN.

Reset
REQ-034 RST=0 sampled at an edge puts the FSM in IDLE, clears stack pointer, stk_ovf and stk_unf, from any state, including mid-FLUSH or HALTED.
REQ-035 While RST=0: ctrl=10, jump=0, flush=0, redir_ready=0; stack contents are don't-care.

Verification
REQ-036 Release reset, imem_ready=1, stall=0: ctrl=10 one cycle (IDLE), then 00 every cycle.
REQ-037 In RUN, pc_in=0x10, call to 0x100: ctrl=01, jump=0x100; next cycle flush=1, ctrl=10; a later return gives ctrl=01, jump=0x11.
REQ-038 Five calls with STACK_DEPTH=4: fifth call still jumps and sets stk_ovf=1; four returns yield addresses in LIFO order; a fifth return sets stk_unf=1 with ctrl=10.
REQ-039 stall=1 and redir_valid=1 (jump 0x40) together: ctrl=01, jump=0x40; with stall=1 alone: ctrl=10; with imem_ready=0: ctrl=10.
REQ-040 halt=1 with redir_valid=1: redirect dropped, ctrl=10 until resume; halt and resume both high stays HALTED.
REQ-041 RST=0 asserted during FLUSH with stk_ovf=1: next cycle IDLE, stk_ovf=0, stack empty, so a return sets stk_unf.
